// File: rtl/ras_spec_arch.sv
// ras_spec_arch: speculative + architectural return address stack with flush restore.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   fetch_valid/fetch_pc/slot_*    fetch group; lowest-index CALL/RET slot drives the speculative copy
//   flush                          speculative copy reloads the architectural next state
//   retire_valid/pc/type           retiring branch drives the architectural copy
//   ret_pc, ret_valid, ras_full    speculative top entry, non-empty, full
// Optional: define RAS_RECUR_CNT_EN to compress repeated identical calls into per-entry counters.
module ras_spec_arch #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  parameter int SLOTS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fetch_valid,
  input  logic [SLOTS*32-1:0]  fetch_pc,
  input  logic [SLOTS-1:0]     slot_valid,
  input  logic [SLOTS*3-1:0]   slot_type,
  input  logic                 flush,
  input  logic                 retire_valid,
  input  logic [31:0]          retire_pc,
  input  logic [2:0]           retire_type,
  output logic [31:0]          ret_pc,
  output logic                 ret_valid,
  output logic                 ras_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [2:0] BR_CALL = 3'b010;
  localparam logic [2:0] BR_RET  = 3'b011;
  // index 0 = speculative copy, index 1 = architectural copy
  logic [31:0]   pc_q [2][DEPTH];
  logic [31:0]   pc_d [2][DEPTH];
  logic [AW-1:0] top_q [2];
  logic [AW-1:0] top_d [2];
  logic [AW-1:0] tn [2];
  logic [AW-1:0] tp [2];
  logic [OW-1:0] occ_q [2];
  logic [OW-1:0] occ_d [2];
  logic          push [2];
  logic          pop [2];
  logic          comp [2];
  logic          deep [2];
  logic [31:0]   link [2];
  logic          f_hit;
  logic          f_call;
  logic [31:0]   f_pc;
`ifdef RAS_RECUR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q [2][DEPTH];
  logic [CNT_W-1:0] cnt_d [2][DEPTH];
`endif
  // descending scan: the last hit written is the lowest-index CALL/RET slot
  always_comb begin
    f_hit  = 1'b0;
    f_call = 1'b0;
    f_pc   = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (slot_valid[i] && (slot_type[3*i+:3] == BR_CALL || slot_type[3*i+:3] == BR_RET)) begin
        f_hit  = 1'b1;
        f_call = slot_type[3*i+:3] == BR_CALL;
        f_pc   = fetch_pc[32*i+:32];
      end
  end
  // masking the low bits and adding 4 equals the 30-bit word increment, wrapping to 0
  always_comb begin
    push[0] = fetch_valid && !flush && f_hit && f_call;
    pop[0]  = fetch_valid && !flush && f_hit && !f_call;
    link[0] = (f_pc & ~32'h3) + 32'd4;
    push[1] = retire_valid && retire_type == BR_CALL;
    pop[1]  = retire_valid && retire_type == BR_RET;
    link[1] = (retire_pc & ~32'h3) + 32'd4;
  end
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      pc_d[c]  = pc_q[c];
      top_d[c] = top_q[c];
      occ_d[c] = occ_q[c];
      tn[c]    = top_q[c] + 1'b1;
      tp[c]    = top_q[c] - 1'b1;
`ifdef RAS_RECUR_CNT_EN
      cnt_d[c] = cnt_q[c];
      comp[c]  = occ_q[c] != '0 && pc_q[c][top_q[c]] == link[c] && cnt_q[c][top_q[c]] != CNT_MAX;
      deep[c]  = cnt_q[c][top_q[c]] > CNT_W'(1);
`else
      comp[c]  = 1'b0;
      deep[c]  = 1'b0;
`endif
      if (push[c] && comp[c]) begin
`ifdef RAS_RECUR_CNT_EN
        cnt_d[c][top_q[c]] = cnt_q[c][top_q[c]] + 1'b1;
`endif
      end else if (push[c]) begin
        pc_d[c][tn[c]] = link[c];
`ifdef RAS_RECUR_CNT_EN
        cnt_d[c][tn[c]] = CNT_W'(1);
`endif
        top_d[c] = tn[c];
        occ_d[c] = occ_q[c] == FULL ? occ_q[c] : occ_q[c] + 1'b1;
      end else if (pop[c] && occ_q[c] != '0 && deep[c]) begin
`ifdef RAS_RECUR_CNT_EN
        cnt_d[c][top_q[c]] = cnt_q[c][top_q[c]] - 1'b1;
`endif
      end else if (pop[c] && occ_q[c] != '0) begin
`ifdef RAS_RECUR_CNT_EN
        cnt_d[c][top_q[c]] = '0;
`endif
        top_d[c] = tp[c];
        occ_d[c] = occ_q[c] - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 2; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          pc_q[c][e] <= '0;
`ifdef RAS_RECUR_CNT_EN
          cnt_q[c][e] <= '0;
`endif
        end
        top_q[c] <= '0;
        occ_q[c] <= '0;
      end
    end else begin
      pc_q[1]  <= pc_d[1];
      top_q[1] <= top_d[1];
      occ_q[1] <= occ_d[1];
`ifdef RAS_RECUR_CNT_EN
      cnt_q[1] <= cnt_d[1];
`endif
      // flush restores from the architectural next state, so a same-cycle retire is included
      if (flush) begin
        pc_q[0]  <= pc_d[1];
        top_q[0] <= top_d[1];
        occ_q[0] <= occ_d[1];
`ifdef RAS_RECUR_CNT_EN
        cnt_q[0] <= cnt_d[1];
`endif
      end else begin
        pc_q[0]  <= pc_d[0];
        top_q[0] <= top_d[0];
        occ_q[0] <= occ_d[0];
`ifdef RAS_RECUR_CNT_EN
        cnt_q[0] <= cnt_d[0];
`endif
      end
    end
  end
  assign ret_pc    = pc_q[0][top_q[0]];
  assign ret_valid = occ_q[0] != '0;
  assign ras_full  = occ_q[0] == FULL;
endmodule

// File: tb/tb_ras_spec_arch.sv
// tb_ras_spec_arch: directed self-checking bench for ras_spec_arch (DEPTH=16, SLOTS=2).
module tb_ras_spec_arch;
  localparam logic [2:0] CALL = 3'b010;
  localparam logic [2:0] RET  = 3'b011;
  localparam logic [2:0] JMP  = 3'b001;
  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [1:0]  slot_valid;
  logic [5:0]  slot_type;
  logic        flush;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [2:0]  retire_type;
  logic [31:0] ret_pc;
  logic        ret_valid;
  logic        ras_full;
  int checks = 0;
  int failures = 0;
  ras_spec_arch #(.DEPTH(16), .CNT_W(8), .SLOTS(2)) dut (
    .clk(clk), .resetn(resetn), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .slot_valid(slot_valid), .slot_type(slot_type), .flush(flush),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_type(retire_type),
    .ret_pc(ret_pc), .ret_valid(ret_valid), .ras_full(ras_full)
  );
  always #5 clk = ~clk;
  task automatic idle();
    fetch_valid = 1'b0;
    fetch_pc = '0;
    slot_valid = '0;
    slot_type = '0;
    flush = 1'b0;
    retire_valid = 1'b0;
    retire_pc = '0;
    retire_type = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic do_reset();
    idle();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask
  task automatic group(input logic [1:0] v, input logic [2:0] t0, input logic [31:0] p0,
                       input logic [2:0] t1, input logic [31:0] p1);
    fetch_valid = 1'b1;
    slot_valid = v;
    slot_type = {t1, t0};
    fetch_pc = {p1, p0};
  endtask
  task automatic call(input logic [31:0] p);
    group(2'b01, CALL, p, 3'b000, 32'h0);
    step();
  endtask
  task automatic ret();
    group(2'b01, RET, 32'h0, 3'b000, 32'h0);
    step();
  endtask
  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #2;
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL reset_ret_pc got=%h exp=%h", ret_pc, 32'h0); end
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL reset_ret_valid got=%b exp=0", ret_valid); end
    checks++; if (ras_full !== 1'b0) begin failures++; $display("FAIL reset_ras_full got=%b exp=0", ras_full); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    call(32'h1111_0000);
    checks++; if (ret_valid !== 1'b1) begin failures++; $display("FAIL pre_async_valid got=%b exp=1", ret_valid); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", ret_valid); end
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL async_reset_pc got=%h exp=0", ret_pc); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask
  task automatic test_call_ret();
    do_reset();
    call(32'h1C00_0100);
    checks++; if (ret_pc !== 32'h1C00_0104) begin failures++; $display("FAIL call_ret_pc got=%h exp=%h", ret_pc, 32'h1C00_0104); end
    checks++; if (ret_valid !== 1'b1) begin failures++; $display("FAIL call_ret_valid got=%b exp=1", ret_valid); end
    group(2'b10, 3'b000, 32'h0, RET, 32'h1C00_0200);
    step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL slot1_ret_valid got=%b exp=0", ret_valid); end
    call(32'hFFFF_FFFE);
    checks++; if (ret_pc !== 32'h0 || ret_valid !== 1'b1) begin failures++; $display("FAIL link_wrap got=%h/%b exp=00000000/1", ret_pc, ret_valid); end
    group(2'b01, CALL, 32'h1234_5000, 3'b000, 32'h0);
    fetch_valid = 1'b0;
    step();
    checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL fetch_invalid got=%h exp=0", ret_pc); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 16; k++) call(32'h1000 + 32'(k) * 32'h10);
    checks++; if (ras_full !== 1'b1 || ret_pc !== 32'h10F4) begin failures++; $display("FAIL full16 got=%b/%h exp=1/000010f4", ras_full, ret_pc); end
    call(32'h1100);
    checks++; if (ras_full !== 1'b1 || ret_pc !== 32'h1104) begin failures++; $display("FAIL full17 got=%b/%h exp=1/00001104", ras_full, ret_pc); end
    ret();
    checks++; if (ras_full !== 1'b0 || ret_pc !== 32'h10F4) begin failures++; $display("FAIL pop1 got=%b/%h exp=0/000010f4", ras_full, ret_pc); end
    for (int k = 0; k < 14; k++) ret();
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h1014) begin failures++; $display("FAIL pop15 got=%b/%h exp=1/00001014", ret_valid, ret_pc); end
    ret();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL pop16 got=%b exp=0", ret_valid); end
    ret();
    checks++; if (ret_valid !== 1'b0 || ret_pc !== 32'h1104 || ras_full !== 1'b0) begin failures++; $display("FAIL underflow got=%b/%h exp=0/00001104", ret_valid, ret_pc); end
  endtask
  task automatic test_recursion();
    logic exp_full;
    logic exp_v16;
`ifdef RAS_RECUR_CNT_EN
    exp_full = 1'b0;
    exp_v16 = 1'b1;
`else
    exp_full = 1'b1;
    exp_v16 = 1'b0;
`endif
    do_reset();
    for (int k = 0; k < 3; k++) call(32'h2000);
    ret();
    ret();
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h2004) begin failures++; $display("FAIL recur_two_pops got=%b/%h exp=1/00002004", ret_valid, ret_pc); end
    ret();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL recur_three_pops got=%b exp=0", ret_valid); end
    do_reset();
    for (int k = 0; k < 256; k++) call(32'h2000);
    checks++; if (ras_full !== exp_full) begin failures++; $display("FAIL recur_full got=%b exp=%b", ras_full, exp_full); end
    for (int k = 0; k < 16; k++) ret();
    checks++; if (ret_valid !== exp_v16) begin failures++; $display("FAIL recur_after16 got=%b exp=%b", ret_valid, exp_v16); end
`ifdef RAS_RECUR_CNT_EN
    for (int k = 0; k < 239; k++) ret();
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h2004) begin failures++; $display("FAIL sat_after255 got=%b/%h exp=1/00002004", ret_valid, ret_pc); end
    ret();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL sat_after256 got=%b exp=0", ret_valid); end
`endif
  endtask
  task automatic test_slot_priority();
    do_reset();
    call(32'h7000);
    group(2'b11, RET, 32'h0, CALL, 32'h8000);
    step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL ret_then_call got=%b exp=0", ret_valid); end
    group(2'b10, CALL, 32'h8100, CALL, 32'h8200);
    step();
    checks++; if (ret_pc !== 32'h8204) begin failures++; $display("FAIL slot0_invalid got=%h exp=00008204", ret_pc); end
    group(2'b11, JMP, 32'h8300, CALL, 32'h9000);
    step();
    checks++; if (ret_pc !== 32'h9004) begin failures++; $display("FAIL slot0_jmp got=%h exp=00009004", ret_pc); end
    ret();
    checks++; if (ret_pc !== 32'h8204) begin failures++; $display("FAIL slot0_jmp_pop got=%h exp=00008204", ret_pc); end
  endtask
  task automatic test_flush();
    do_reset();
    retire_valid = 1'b1;
    retire_type = CALL;
    retire_pc = 32'h3000;
    step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL retire_no_spec got=%b exp=0", ret_valid); end
    call(32'h4000);
    call(32'h5000);
    checks++; if (ret_pc !== 32'h5004) begin failures++; $display("FAIL spec_before_flush got=%h exp=00005004", ret_pc); end
    flush = 1'b1;
    step();
    checks++; if (ret_pc !== 32'h3004 || ret_valid !== 1'b1) begin failures++; $display("FAIL flush_restore got=%h/%b exp=00003004/1", ret_pc, ret_valid); end
    ret();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL flush_occ1 got=%b exp=0", ret_valid); end
  endtask
  task automatic test_flush_retire();
    do_reset();
    call(32'hA000);
    flush = 1'b1;
    retire_valid = 1'b1;
    retire_type = CALL;
    retire_pc = 32'h6000;
    group(2'b01, CALL, 32'hB000, 3'b000, 32'h0);
    step();
    checks++; if (ret_pc !== 32'h6004 || ret_valid !== 1'b1) begin failures++; $display("FAIL flush_retire got=%h/%b exp=00006004/1", ret_pc, ret_valid); end
    group(2'b01, CALL, 32'hC000, 3'b000, 32'h0);
    retire_valid = 1'b1;
    retire_type = RET;
    step();
    checks++; if (ret_pc !== 32'hC004) begin failures++; $display("FAIL concurrent_fetch got=%h exp=0000c004", ret_pc); end
    flush = 1'b1;
    step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL arch_popped got=%b exp=0", ret_valid); end
  endtask
  initial begin
    test_reset();
    test_call_ret();
    test_overflow();
    test_recursion();
    test_slot_priority();
    test_flush();
    test_flush_retire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
